// File: rtl/irq_sequencer_if.sv
// ---------------------------------------------------------------------------
// irq_sequencer_if
// Bundles every non-clock/reset signal of the interrupt sequencer.
//   Core/CSR -> sequencer : int_src, mie, mtvec, pc, core_ready, mret
//   Sequencer -> core/CSR : mcause, en_mepc, mepc_csr, pc_sel, trap_pc,
//                           int_ack, in_service, pending
// Modports:
//   master : the environment (core, CSR block, interrupt sources)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface irq_sequencer_if #(
    parameter int N_IRQ = 6
);
    logic [N_IRQ-1:0] int_src;
    logic [N_IRQ-1:0] mie;
    logic [31:0]      mtvec;
    logic [31:0]      pc;
    logic             core_ready;
    logic             mret;

    logic [31:0]      mcause;
    logic             en_mepc;
    logic [31:0]      mepc_csr;
    logic             pc_sel;
    logic [31:0]      trap_pc;
    logic [N_IRQ-1:0] int_ack;
    logic             in_service;
    logic [N_IRQ-1:0] pending;

    modport master (
        output int_src, mie, mtvec, pc, core_ready, mret,
        input  mcause, en_mepc, mepc_csr, pc_sel, trap_pc, int_ack,
               in_service, pending
    );

    modport slave (
        input  int_src, mie, mtvec, pc, core_ready, mret,
        output mcause, en_mepc, mepc_csr, pc_sel, trap_pc, int_ack,
               in_service, pending
    );
endinterface

// File: rtl/irq_sequencer.sv
// ---------------------------------------------------------------------------
// irq_sequencer
// Edge-detects N_IRQ interrupt lines into a pending register, masks them with
// mie, picks the lowest-index eligible source and, at an instruction boundary,
// performs a one-cycle trap entry (mepc write, mcause load, fetch redirect to
// the vectored handler, source acknowledge). Further entries are blocked
// until mret, so handlers never nest.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : irq_sequencer_if.slave (see interface file for signal list)
// ---------------------------------------------------------------------------
module irq_sequencer #(
    parameter int N_IRQ      = 6,
    parameter int CAUSE_BASE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    irq_sequencer_if.slave       bus
);
    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTER   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [N_IRQ-1:0] src_q_r;
    logic [N_IRQ-1:0] pending_r;
    logic [ID_W-1:0]  id_r;
    logic [31:0]      epc_q_r;
    logic [31:0]      mcause_r;

    logic [N_IRQ-1:0] rise_s;
    logic [N_IRQ-1:0] eligible_s;
    logic [N_IRQ-1:0] ack_oh_s;
    logic [N_IRQ-1:0] clr_s;
    logic [ID_W-1:0]  win_id_s;
    logic             start_s;
    logic [30:0]      cause_s;

    assign rise_s     = bus.int_src & ~src_q_r;
    assign eligible_s = pending_r & bus.mie;
    assign start_s    = (|eligible_s) & bus.core_ready;
    assign ack_oh_s   = {{(N_IRQ-1){1'b0}}, 1'b1} << id_r;
    assign clr_s      = (state_r == ENTER) ? ack_oh_s : {N_IRQ{1'b0}};
    assign cause_s    = 31'(CAUSE_BASE) + 31'(id_r);

    // Priority encoder: scanning downward lets the lowest eligible index win.
    always_comb begin
        win_id_s = {ID_W{1'b0}};
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible_s[i]) begin
                win_id_s = ID_W'(i);
            end else begin
                win_id_s = win_id_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state; core_ready and mret only matter in the state that uses them.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nxt_s = ENTER;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ENTER: begin
                state_nxt_s = SERVICE;
            end
            SERVICE: begin
                if (bus.mret) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SERVICE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Edge detector and pending register; a fresh edge beats the ENTER clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q_r   <= {N_IRQ{1'b0}};
            pending_r <= {N_IRQ{1'b0}};
        end else begin
            src_q_r   <= bus.int_src;
            pending_r <= (pending_r & ~clr_s) | rise_s;
        end
    end

    // Capture the winner and return address on IDLE->ENTER; load mcause at the end of ENTER.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_r     <= {ID_W{1'b0}};
            epc_q_r  <= 32'd0;
            mcause_r <= 32'd0;
        end else begin
            if ((state_r == IDLE) && start_s) begin
                id_r    <= win_id_s;
                epc_q_r <= bus.pc;
            end
            if (state_r == ENTER) begin
                mcause_r <= {1'b1, cause_s};
            end
        end
    end

    // Output decode; strobes and address buses are driven only during ENTER.
    always_comb begin
        bus.en_mepc  = 1'b0;
        bus.mepc_csr = 32'd0;
        bus.pc_sel   = 1'b0;
        bus.trap_pc  = 32'd0;
        bus.int_ack  = {N_IRQ{1'b0}};
        if (state_r == ENTER) begin
            bus.en_mepc  = 1'b1;
            bus.mepc_csr = epc_q_r;
            bus.pc_sel   = 1'b1;
            bus.trap_pc  = {bus.mtvec[31:2], 2'b00} + (32'(id_r) << 2);
            bus.int_ack  = ack_oh_s;
        end else begin
            bus.int_ack  = {N_IRQ{1'b0}};
        end
    end

    assign bus.in_service = (state_r != IDLE);
    assign bus.pending    = pending_r;
    assign bus.mcause     = mcause_r;

endmodule

// File: tb/tb_irq_sequencer.sv
// ---------------------------------------------------------------------------
// tb_irq_sequencer
// Directed bench for irq_sequencer: single source, priority/no-nesting,
// masking, core_ready gating, reset mid-service, stray mret, re-edge during
// ENTER and trap_pc wrap-around. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_irq_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    irq_sequencer_if #(.N_IRQ(6)) bus ();

    irq_sequencer #(.N_IRQ(6), .CAUSE_BASE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.int_src    = 6'h00;
        bus.mie        = 6'h00;
        bus.mtvec      = 32'h0000_0000;
        bus.pc         = 32'h0000_0000;
        bus.core_ready = 1'b0;
        bus.mret       = 1'b0;
        tick();
        tick();
        // Reset state
        check("rst_pc_sel",     32'(bus.pc_sel),     32'd0);
        check("rst_in_service", 32'(bus.in_service), 32'd0);
        check("rst_mcause",     bus.mcause,          32'd0);
        check("rst_pending",    32'(bus.pending),    32'd0);
        check("rst_int_ack",    32'(bus.int_ack),    32'd0);
        rst = 1'b0;

        // Single source 2
        bus.mie        = 6'h3F;
        bus.core_ready = 1'b1;
        bus.pc         = 32'h0000_0100;
        bus.mtvec      = 32'h0000_0200;
        bus.int_src    = 6'h04;
        tick();
        check("s1_pending", 32'(bus.pending), 32'h04);
        check("s1_no_entry_yet", 32'(bus.pc_sel), 32'd0);
        bus.int_src = 6'h00;
        tick();
        check("s1_pc_sel",   32'(bus.pc_sel),  32'd1);
        check("s1_trap_pc",  bus.trap_pc,      32'h0000_0208);
        check("s1_en_mepc",  32'(bus.en_mepc), 32'd1);
        check("s1_mepc_csr", bus.mepc_csr,     32'h0000_0100);
        check("s1_int_ack",  32'(bus.int_ack), 32'h04);
        tick();
        check("s1_pc_sel_done", 32'(bus.pc_sel),     32'd0);
        check("s1_mcause",      bus.mcause,          32'h8000_0012);
        check("s1_pending_clr", 32'(bus.pending),    32'd0);
        check("s1_in_service",  32'(bus.in_service), 32'd1);
        check("s1_ack_done",    32'(bus.int_ack),    32'd0);
        bus.mret = 1'b1;
        tick();
        bus.mret = 1'b0;
        check("s1_idle",        32'(bus.in_service), 32'd0);
        check("s1_mcause_held", bus.mcause,          32'h8000_0012);

        // Priority: sources 4 and 1 together
        bus.int_src = 6'h12;
        tick();
        check("pr_pending", 32'(bus.pending), 32'h12);
        bus.int_src = 6'h00;
        tick();
        check("pr_first_trap", bus.trap_pc,      32'h0000_0204);
        check("pr_first_ack",  32'(bus.int_ack), 32'h02);
        tick();
        check("pr_pending_left", 32'(bus.pending), 32'h10);
        check("pr_mcause1",      bus.mcause,       32'h8000_0011);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pr_no_nest", 32'(bus.pc_sel), 32'd0);
        end
        bus.mret = 1'b1;
        tick();
        bus.mret = 1'b0;
        check("pr_idle_after_mret", 32'(bus.pc_sel), 32'd0);
        tick();
        check("pr_second_trap", bus.trap_pc,      32'h0000_0210);
        check("pr_second_ack",  32'(bus.int_ack), 32'h10);
        tick();
        check("pr_pending_empty", 32'(bus.pending), 32'd0);
        check("pr_mcause4",       bus.mcause,       32'h8000_0014);
        bus.mret = 1'b1;
        tick();
        bus.mret = 1'b0;

        // Masking
        bus.mie     = 6'h00;
        bus.int_src = 6'h01;
        tick();
        bus.int_src = 6'h00;
        check("mk_pending", 32'(bus.pending), 32'h01);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("mk_no_entry", 32'(bus.pc_sel), 32'd0);
        end
        check("mk_pending_kept", 32'(bus.pending), 32'h01);
        bus.mie = 6'h01;
        tick();
        check("mk_entry",   32'(bus.pc_sel),  32'd1);
        check("mk_trap_pc", bus.trap_pc,      32'h0000_0200);
        check("mk_ack",     32'(bus.int_ack), 32'h01);
        tick();
        check("mk_mcause", bus.mcause, 32'h8000_0010);
        bus.mret = 1'b1;
        tick();
        bus.mret = 1'b0;
        bus.mie  = 6'h3F;

        // core_ready gating, mtvec low bits ignored
        bus.core_ready = 1'b0;
        bus.mtvec      = 32'h0000_0203;
        bus.int_src    = 6'h08;
        tick();
        bus.int_src = 6'h00;
        check("cr_pending", 32'(bus.pending), 32'h08);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("cr_blocked", 32'(bus.in_service), 32'd0);
        end
        bus.pc         = 32'h0000_0ABC;
        bus.core_ready = 1'b1;
        tick();
        check("cr_entry",     32'(bus.pc_sel), 32'd1);
        check("cr_mepc_csr",  bus.mepc_csr,    32'h0000_0ABC);
        check("cr_trap_pc",   bus.trap_pc,     32'h0000_020C);
        tick();
        check("cr_mcause", bus.mcause, 32'h8000_0013);

        // Reset during SERVICE with a pending request
        bus.int_src = 6'h20;
        tick();
        bus.int_src = 6'h00;
        check("rs_pending_before", 32'(bus.pending),    32'h20);
        check("rs_in_service",     32'(bus.in_service), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rs_in_service_0", 32'(bus.in_service), 32'd0);
        check("rs_pending_0",    32'(bus.pending),    32'd0);
        check("rs_mcause_0",     bus.mcause,          32'd0);
        check("rs_pc_sel_0",     32'(bus.pc_sel),     32'd0);
        check("rs_trap_pc_0",    bus.trap_pc,         32'd0);
        check("rs_mepc_csr_0",   bus.mepc_csr,        32'd0);
        tick();
        rst      = 1'b0;
        bus.mret = 1'b1;
        tick();
        bus.mret = 1'b0;
        check("stray_mret_in_service", 32'(bus.in_service), 32'd0);
        check("stray_mret_pc_sel",     32'(bus.pc_sel),     32'd0);
        check("stray_mret_mcause",     bus.mcause,          32'd0);
        tick();
        check("stray_mret_idle", 32'(bus.in_service), 32'd0);

        // Re-edge during ENTER, with trap_pc wrap-around
        bus.mtvec   = 32'hFFFF_FFFC;
        bus.pc      = 32'h0000_0400;
        bus.int_src = 6'h02;
        tick();
        bus.int_src = 6'h00;
        tick();
        check("re_entry",     32'(bus.pc_sel), 32'd1);
        check("re_trap_wrap", bus.trap_pc,     32'h0000_0000);
        check("re_mepc_csr",  bus.mepc_csr,    32'h0000_0400);
        bus.int_src = 6'h02;
        tick();
        bus.int_src = 6'h00;
        check("re_pending_kept", 32'(bus.pending), 32'h02);
        check("re_no_nest",      32'(bus.pc_sel),  32'd0);
        tick();
        check("re_still_service", 32'(bus.in_service), 32'd1);
        check("re_still_no_nest", 32'(bus.pc_sel),     32'd0);
        bus.mret = 1'b1;
        tick();
        bus.mret = 1'b0;
        tick();
        check("re_second_entry", 32'(bus.pc_sel),  32'd1);
        check("re_second_ack",   32'(bus.int_ack), 32'h02);
        tick();
        check("re_pending_clr", 32'(bus.pending), 32'd0);
        bus.mret = 1'b1;
        tick();
        bus.mret = 1'b0;
        check("re_idle", 32'(bus.in_service), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
